// File: rtl/fifo_v4_sram.sv
// Synchronous FIFO backed by a simple-dual-port RAM with synchronous read.
// The head word is read from the RAM one edge ahead: the read address is the
// next read pointer, so a pop never leaves a bubble. A word written at the
// same edge as the RAM reads its address is captured into a bypass register.
// Optional first-word fall-through serves data_i directly while empty.
module fifo_v4_sram #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int FALL_THROUGH = 0,
    parameter int AF_THRESH    = DEPTH - 1,
    parameter int AE_THRESH    = 1,
    localparam int PTR_W       = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Storage and its synchronous read port
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] byp_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_addr;
    logic [CNT_W-1:0] usage_q, usage_d;
    logic             byp_sel_q, byp_sel_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic             full, empty;
    logic             ft_pass, push_acc, pop_acc;

    // Pointers wrap at DEPTH-1, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Status is derived from registered occupancy only
    assign full  = (int'(usage_q) == DEPTH);
    assign empty = (usage_q == '0);

    // Fall-through push+pop on an empty queue moves the word straight across
    assign ft_pass  = (FALL_THROUGH != 0) && empty && push_i && pop_i;
    assign push_acc = push_i && !full && !ft_pass;
    assign pop_acc  = pop_i && !empty;

    // Next-state: pointers, occupancy, bypass select and sticky error flags
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        usage_d   = usage_q;
        byp_sel_d = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        wr_en     = 1'b0;
        rd_addr   = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
            rd_addr  = '0;
        end else begin
            if (push_acc) begin
                wr_en    = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push_acc && !pop_acc) begin
                usage_d = usage_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                usage_d = usage_q - CNT_W'(1);
            end
            if (push_i && full) begin
                ovf_d = 1'b1;
            end
            if (pop_i && empty && !ft_pass) begin
                unf_d = 1'b1;
            end
            rd_addr   = rd_ptr_d;
            byp_sel_d = push_acc && (wr_ptr_q == rd_ptr_d);
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usage_q   <= '0;
            byp_sel_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usage_q   <= usage_d;
            byp_sel_q <= byp_sel_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // RAM write port
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // RAM synchronous read of the upcoming head address
    always_ff @(posedge clk_i) begin
        ram_q <= mem[rd_addr];
    end

    // Capture of a word written into the address being read at the same edge
    always_ff @(posedge clk_i) begin
        if (byp_sel_d && !rst_i) begin
            byp_q <= data_i;
        end
    end

    // Head word selection, with optional fall-through from data_i while empty
    always_comb begin
        if ((FALL_THROUGH != 0) && empty && push_i) begin
            data_o = data_i;
        end else if (byp_sel_q) begin
            data_o = byp_q;
        end else begin
            data_o = ram_q;
        end
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (int'(usage_q) >= AF_THRESH);
    assign almost_empty_o = (int'(usage_q) <= AE_THRESH);
    assign usage_o        = usage_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: doc/fifo_v4_sram.md
FIFO_V4_SRAM -- requirements
Module: fifo_v4_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (1..1024).
REQ-002 SHALL have parameter DEPTH, default 8, word capacity, any integer >= 2, power of two not required.
REQ-003 SHALL have parameter FALL_THROUGH, default 0, 1 = first-word fall-through from data_i when empty.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-1, almost_full_o asserts at usage >= AF_THRESH.
REQ-005 SHALL have parameter AE_THRESH, default 1, almost_empty_o asserts at usage <= AE_THRESH.
REQ-006 SHALL have derived localparams PTR_W = max(1, $clog2(DEPTH)) and CNT_W = $clog2(DEPTH+1); these are not overridable.
REQ-007 SHALL have port clk_i, input, 1, sole clock, all state on its rising edge.
REQ-008 SHALL have port rst_i, input, 1: one clock; reset is synchronous and active-high.
REQ-009 SHALL have port flush_i, input, 1, synchronous queue clear.
REQ-010 SHALL have port data_i, input, DATA_WIDTH, push data.
REQ-011 SHALL have port push_i, input, 1, push request.
REQ-012 SHALL have port pop_i, input, 1, pop request.
REQ-013 SHALL have port data_o, output, DATA_WIDTH, head word.
REQ-014 SHALL have ports full_o, empty_o, almost_full_o, almost_empty_o, output, 1 each, status flags.
REQ-015 SHALL have port usage_o, output, CNT_W, words held, 0..DEPTH inclusive.
REQ-016 SHALL have ports overflow_o, underflow_o, output, 1 each, sticky error flags.

Function
REQ-017 SHALL store words in a single inferable simple-dual-port RAM, DEPTH x DATA_WIDTH, synchronous read, no vendor macros or primitives.
REQ-018 SHALL keep write and read pointers of PTR_W bits, each wrapping from DEPTH-1 to 0, also for non-power-of-two DEPTH.
REQ-019 SHALL update usage: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
REQ-020 SHALL accept a push iff push_i=1 and full_o=0; a push while full is dropped, state unchanged, overflow_o set next edge.
REQ-021 SHALL accept a pop iff pop_i=1 and empty_o=0; a pop while empty is ignored, underflow_o set next edge; FALL_THROUGH exception in REQ-026.
REQ-022 SHALL derive full_o = (usage==DEPTH), empty_o = (usage==0), almost flags per REQ-004/005, all from registered state only.
REQ-023 SHALL, with FALL_THROUGH=0, present a word pushed at edge N on data_o with empty_o=0 after edge N+1 (1-cycle latency), including into an empty FIFO.
REQ-024 SHALL hold data_o equal to the current head word whenever empty_o=0, with no bubble after a pop while usage>1 (read address = next read pointer on pop).
REQ-025 SHALL bypass RAM read-during-write to the same address with a registered copy of data_i so data_o is never stale.
REQ-026 SHALL, with FALL_THROUGH=1 and empty, drive data_o=data_i combinationally while push_i=1; push_i&pop_i then passes the word through with no storage, usage stays 0, no underflow.
REQ-027 SHALL leave data_o undefined-but-stable (last value) when empty and no fall-through.
REQ-028 SHALL, on flush_i=1, clear pointers, usage and bypass state at that edge, ignoring same-cycle push/pop; error flags are kept.
REQ-029 SHALL give rst_i priority over flush_i, push_i, pop_i.

Reset
REQ-030 SHALL, on rst_i=1 at an edge, set usage_o=0, empty_o=1, full_o=0, almost_empty_o=1 (AE_THRESH>=0), almost_full_o=0, overflow_o=0, underflow_o=0, pointers=0.
REQ-031 SHALL not require RAM contents to be reset; data_o after reset is don't-care until first push.
REQ-032 SHALL honour reset asserted mid-operation (e.g. full FIFO) with REQ-030 values at the next edge.

Verification (DATA_WIDTH=40, DEPTH=6, AF_THRESH=5, AE_THRESH=1)
REQ-033 SHALL cover: reset, push 0xAA_0000_0001 at edge N -> after N+1 empty_o=0, data_o=0xAA00000001, usage_o=1, almost_empty_o=1.
REQ-034 SHALL cover: push 6 words 1..6 -> full_o=1, usage_o=6, almost_full_o=1; 7th push -> usage_o=6, overflow_o=1; pop back-to-back -> data_o 1,2,...,6 one per cycle, no bubbles, then empty_o=1.
REQ-035 SHALL cover: 20 cycles of simultaneous push/pop at usage_o=3 across pointer wrap -> usage_o stays 3, output order matches input order.
REQ-036 SHALL cover: pop on empty -> underflow_o=1, usage_o=0; flush_i at usage 4 -> usage_o=0, empty_o=1, underflow_o still 1; rst_i -> both flags 0.
REQ-037 SHALL cover: FALL_THROUGH=1, empty, push_i=pop_i=1 data_i=0x55 -> same cycle data_o=0x55, usage_o stays 0, underflow_o=0.
REQ-038 SHALL cover: rst_i and flush_i with push_i while full -> next edge usage_o=0, overflow_o=0.
